l2_arbiter_rr: RTL
==================

L2_ARBITER_RR -- requirements
Module: l2_arbiter_rr

Interface
REQ-001 Parameter: RR_EN, 1, 1 = round-robin between I and D on conflict; 0 = fixed priority, I always wins.
REQ-002 clk  in  1  system clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 l1_i_read  in  1  I-cache line read request, level, held until l1_i_resp.
REQ-005 l1_i_address  in  16  I-cache line address.
REQ-006 l1_i_rdata  out  128  line returned to I-cache.
REQ-007 l1_i_resp  out  1  one-cycle I completion pulse.
REQ-008 l1_d_read  in  1  D-cache line read request, level, held until l1_d_resp.
REQ-009 l1_d_write  in  1  D-cache line write request, level, held until l1_d_resp.
REQ-010 l1_d_address  in  16  D-cache line address.
REQ-011 l1_d_wdata  in  128  D-cache write line.
REQ-012 l1_d_rdata  out  128  line returned to D-cache.
REQ-013 l1_d_resp  out  1  one-cycle D completion pulse.
REQ-014 l2_rdata  in  128  L2 read line.
REQ-015 l2_resp  in  1  L2 completion, valid while l2_read/l2_write high.
REQ-016 l2_read  out  1  read request to L2.
REQ-017 l2_write  out  1  write request to L2.
REQ-018 l2_address  out  16  latched L2 address.
REQ-019 l2_wdata  out  128  latched L2 write line.
REQ-020 d_illegal  out  1  sticky: l1_d_read and l1_d_write seen together in IDLE.
REQ-021 conflict_cnt  out  16  saturating count of IDLE cycles where I and D both requested.

Function
REQ-022 States SHALL be IDLE, I_RD, D_RD, D_WR, I_DONE, D_DONE.
REQ-023 IDLE, I request only: latch l2_address <= l1_i_address, go I_RD.
REQ-024 IDLE, D only: d_read -> latch address, go D_RD; d_write -> latch address and l2_wdata <= l1_d_wdata, go D_WR.
REQ-025 IDLE, d_read and d_write both high: no D grant, set d_illegal, stay IDLE unless I requests (then grant I).
REQ-026 IDLE, valid I and D requests together: RR_EN=0 grant I; RR_EN=1 grant requester not granted last (last_grant flag, reset value D so I wins first conflict).
REQ-027 last_grant SHALL update only on a grant from IDLE, to the granted side.
REQ-028 conflict_cnt SHALL increment on each IDLE cycle with l1_i_read high and a valid D request, saturating at 16'hFFFF.
REQ-029 l2_read = state in {I_RD, D_RD}; l2_write = state D_WR; both combinational from state, never high together.
REQ-030 I_RD/D_RD with l2_resp: capture l2_rdata into l1_i_rdata / l1_d_rdata, go I_DONE / D_DONE; without l2_resp: hold.
REQ-031 D_WR with l2_resp: go D_DONE.
REQ-032 l1_i_resp = (state == I_DONE); l1_d_resp = (state == D_DONE); each high exactly one cycle.
REQ-033 I_DONE and D_DONE SHALL go to IDLE unconditionally; no grant from a DONE state.
REQ-034 Latency: request high at edge N -> l2_read/l2_write high from N+1; l2_resp at edge M -> L1 resp high cycle after M, IDLE at M+2.
REQ-035 l2_address, l2_wdata, l1_i_rdata and l1_d_rdata SHALL hold value outside their load conditions.
REQ-036 Requests dropped before grant SHALL be ignored; inputs sampled only in IDLE.

Reset
REQ-037 On rst high at posedge: state IDLE, last_grant D, d_illegal 0, conflict_cnt 0, l2_address 0, l2_wdata 0, l1_i_rdata 0, l1_d_rdata 0.
REQ-038 rst mid-transaction SHALL abort it: l2_read/l2_write low and no L1 resp the cycle after reset, l2_resp ignored.
REQ-039 rst SHALL take priority over all other inputs in the same cycle.

Verification
REQ-040 I read 16'h1230 alone, l2_resp after 3 cycles with 128'hA5..A5 -> l2_read 3 cycles, l1_i_rdata = A5..A5, l1_i_resp one pulse, IDLE.
REQ-041 D write 16'h4000, wdata 128'h1 -> l2_write high, l2_address 16'h4000, l2_wdata 128'h1, one l1_d_resp, l1_d_rdata unchanged.
REQ-042 RR_EN=1, I and D read held together for three transactions -> grants I, D, I; conflict_cnt = 2 (third conflict counted only if D still requesting).
REQ-043 RR_EN=0, same stimulus -> I granted every time D competes; D granted only when I idle.
REQ-044 d_read and d_write both high in IDLE, I idle -> no L2 access, d_illegal = 1 and held until rst.
REQ-045 rst asserted during D_RD with l2_resp in same cycle -> IDLE next cycle, no l1_d_resp, l1_d_rdata = 0.

Source files
------------

// File: rtl/l2_arbiter_rr.sv
// Arbitrates I-cache and D-cache line requests onto a single L2 port.
// One transaction in flight; optional round-robin between I and D on conflict.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | sample L1 requests, arbitrate, latch address / write line
// I_RD    | L2 read on behalf of I-cache, wait for l2_resp
// D_RD    | L2 read on behalf of D-cache, wait for l2_resp
// D_WR    | L2 write on behalf of D-cache, wait for l2_resp
// I_DONE  | one-cycle l1_i_resp, back to IDLE
// D_DONE  | one-cycle l1_d_resp, back to IDLE
module l2_arbiter_rr #(
    parameter bit RR_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         l1_i_read,
    input  logic [15:0]  l1_i_address,
    output logic [127:0] l1_i_rdata,
    output logic         l1_i_resp,
    input  logic         l1_d_read,
    input  logic         l1_d_write,
    input  logic [15:0]  l1_d_address,
    input  logic [127:0] l1_d_wdata,
    output logic [127:0] l1_d_rdata,
    output logic         l1_d_resp,
    input  logic [127:0] l2_rdata,
    input  logic         l2_resp,
    output logic         l2_read,
    output logic         l2_write,
    output logic [15:0]  l2_address,
    output logic [127:0] l2_wdata,
    output logic         d_illegal,
    output logic [15:0]  conflict_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_I_RD,
        S_D_RD,
        S_D_WR,
        S_I_DONE,
        S_D_DONE
    } state_t;

    state_t         state_q, state_d;
    logic           last_grant_q, last_grant_d;   // 1: D was granted last
    logic           d_illegal_q, d_illegal_d;
    logic [15:0]    conflict_cnt_q, conflict_cnt_d;
    logic [15:0]    l2_address_q, l2_address_d;
    logic [127:0]   l2_wdata_q, l2_wdata_d;
    logic [127:0]   l1_i_rdata_q, l1_i_rdata_d;
    logic [127:0]   l1_d_rdata_q, l1_d_rdata_d;

    logic           d_valid;
    logic           d_both;
    logic           grant_i;
    logic           grant_d;

    // A D request is only valid when exactly one of read/write is asserted.
    assign d_valid = l1_d_read ^ l1_d_write;
    assign d_both  = l1_d_read & l1_d_write;
    assign grant_i = l1_i_read & ~(d_valid & RR_EN & ~last_grant_q);
    assign grant_d = d_valid & ~grant_i;

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        d_illegal_d    = d_illegal_q;
        conflict_cnt_d = conflict_cnt_q;
        l2_address_d   = l2_address_q;
        l2_wdata_d     = l2_wdata_q;
        l1_i_rdata_d   = l1_i_rdata_q;
        l1_d_rdata_d   = l1_d_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (d_both) begin
                    d_illegal_d = 1'b1;
                end
                if (l1_i_read && d_valid && (conflict_cnt_q != 16'hFFFF)) begin
                    conflict_cnt_d = conflict_cnt_q + 16'd1;
                end
                if (grant_i) begin
                    state_d      = S_I_RD;
                    l2_address_d = l1_i_address;
                    last_grant_d = 1'b0;
                end else if (grant_d) begin
                    l2_address_d = l1_d_address;
                    last_grant_d = 1'b1;
                    if (l1_d_write) begin
                        state_d    = S_D_WR;
                        l2_wdata_d = l1_d_wdata;
                    end else begin
                        state_d = S_D_RD;
                    end
                end
            end
            S_I_RD: begin
                if (l2_resp) begin
                    state_d      = S_I_DONE;
                    l1_i_rdata_d = l2_rdata;
                end
            end
            S_D_RD: begin
                if (l2_resp) begin
                    state_d      = S_D_DONE;
                    l1_d_rdata_d = l2_rdata;
                end
            end
            S_D_WR: begin
                if (l2_resp) begin
                    state_d = S_D_DONE;
                end
            end
            S_I_DONE: state_d = S_IDLE;
            S_D_DONE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            last_grant_q   <= 1'b1;
            d_illegal_q    <= 1'b0;
            conflict_cnt_q <= 16'd0;
            l2_address_q   <= 16'd0;
            l2_wdata_q     <= 128'd0;
            l1_i_rdata_q   <= 128'd0;
            l1_d_rdata_q   <= 128'd0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            d_illegal_q    <= d_illegal_d;
            conflict_cnt_q <= conflict_cnt_d;
            l2_address_q   <= l2_address_d;
            l2_wdata_q     <= l2_wdata_d;
            l1_i_rdata_q   <= l1_i_rdata_d;
            l1_d_rdata_q   <= l1_d_rdata_d;
        end
    end

    assign l2_read      = (state_q == S_I_RD) || (state_q == S_D_RD);
    assign l2_write     = (state_q == S_D_WR);
    assign l1_i_resp    = (state_q == S_I_DONE);
    assign l1_d_resp    = (state_q == S_D_DONE);
    assign l2_address   = l2_address_q;
    assign l2_wdata     = l2_wdata_q;
    assign l1_i_rdata   = l1_i_rdata_q;
    assign l1_d_rdata   = l1_d_rdata_q;
    assign d_illegal    = d_illegal_q;
    assign conflict_cnt = conflict_cnt_q;

endmodule
